// File: rtl/fetch_sequencer.sv
// Program-counter owner and IF-stage sequencer: start, sequential fetch, stall, deferred branch, halt.
// Optional performance counters are enabled by defining FETCH_SEQUENCER_PERF_EN.
module fetch_sequencer #(
  parameter int A          = 4,
  parameter int BR_TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] start_addr,
  input  logic         ctrl_branch,
  input  logic         br_resolved,
  input  logic         take_branch,
  input  logic [A-1:0] br_target,
  input  logic         stall,
  input  logic         halt,
  output logic [A-1:0] inst_addr_out,
  output logic         fetch_valid,
  output logic         br_timeout,
  output logic         done
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [15:0]  cycle_cnt,
  output logic [15:0]  fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_WAIT = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(BR_TIMEOUT - 1);

  state_t       state, state_nxt;
  logic [A-1:0] pc_nxt;
  logic [7:0]   tmo_cnt, tmo_cnt_nxt;
  logic         tmo_fire;
  logic         fetch_valid_nxt;
  logic         done_nxt;
  logic         br_timeout_nxt;

  function automatic logic [A-1:0] pc_inc(input logic [A-1:0] pc);
    return pc + A'(1);
  endfunction

  function automatic logic [A-1:0] pc_resolve(input logic [A-1:0] pc,
                                              input logic         taken,
                                              input logic [A-1:0] target);
    return taken ? target : pc_inc(pc);
  endfunction

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] cycle_cnt_nxt;
  logic [15:0] fetch_cnt_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      inst_addr_out <= '0;
      fetch_valid   <= 1'b0;
      br_timeout    <= 1'b0;
      done          <= 1'b0;
      tmo_cnt       <= '0;
`ifdef FETCH_SEQUENCER_PERF_EN
      cycle_cnt     <= '0;
      fetch_cnt     <= '0;
`endif
    end else begin
      state         <= state_nxt;
      inst_addr_out <= pc_nxt;
      fetch_valid   <= fetch_valid_nxt;
      br_timeout    <= br_timeout_nxt;
      done          <= done_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
`ifdef FETCH_SEQUENCER_PERF_EN
      cycle_cnt     <= cycle_cnt_nxt;
      fetch_cnt     <= fetch_cnt_nxt;
`endif
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_nxt   = state;
    pc_nxt      = inst_addr_out;
    tmo_cnt_nxt = tmo_cnt;
    tmo_fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = start_addr;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (ctrl_branch) begin
          if (br_resolved) begin
            pc_nxt = pc_resolve(inst_addr_out, take_branch, br_target);
          end else begin
            state_nxt   = BR_WAIT;
            tmo_cnt_nxt = '0;
          end
        end else if (!stall) begin
          pc_nxt = pc_inc(inst_addr_out);
        end
      end
      BR_WAIT: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (br_resolved) begin
          state_nxt = RUN;
          pc_nxt    = pc_resolve(inst_addr_out, take_branch, br_target);
        end else if (tmo_cnt == TMO_LAST) begin
          // Nobody resolved the branch in time: fall through as not-taken.
          state_nxt = RUN;
          pc_nxt    = pc_inc(inst_addr_out);
          tmo_fire  = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values registered alongside the state
  always_comb begin
    fetch_valid_nxt = (state_nxt == RUN);
    done_nxt        = (state_nxt == HALTED);
    br_timeout_nxt  = tmo_fire;
`ifdef FETCH_SEQUENCER_PERF_EN
    cycle_cnt_nxt = cycle_cnt;
    fetch_cnt_nxt = fetch_cnt;
    if (state == RUN || state == BR_WAIT) begin
      cycle_cnt_nxt = sat_inc16(cycle_cnt);
    end
    if (state == RUN && !stall && !halt) begin
      fetch_cnt_nxt = sat_inc16(fetch_cnt);
    end
`endif
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that owns the program counter and sequences the IF stage / instr_ROM of the 9-bit core.
- Handles program start, sequential fetch, stall hold, branch redirect with deferred resolution, and halt.
- Drives the `inst_addr` input of instr_ROM.
- Receives branch and halt strobes from decode, and branch resolution from execute.

Parameters:
- A, 4, PC / instruction address width in bits.
- BR_TIMEOUT, 4, max cycles in BR_WAIT before forced not-taken resolution; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin execution at start_addr; honoured only in IDLE.
- start_addr  input  A  initial PC loaded on start.
- ctrl_branch  input  1  current instruction (at inst_addr_out) is a branch.
- br_resolved  input  1  branch outcome valid this cycle.
- take_branch  input  1  branch taken; qualified by br_resolved.
- br_target  input  A  branch destination; qualified by br_resolved && take_branch.
- stall  input  1  downstream back-pressure; hold PC.
- halt  input  1  stop execution permanently until reset.
- inst_addr_out  output  A  current PC to instr_ROM.
- fetch_valid  output  1  inst_addr_out is a live fetch (state RUN).
- br_timeout  output  1  one-cycle pulse when BR_WAIT expired.
- done  output  1  high while in HALTED.

Behaviour:
- States: IDLE, RUN, BR_WAIT, HALTED. All outputs registered.
- Reset (any state, mid-branch included):
  - state=IDLE, inst_addr_out=0, fetch_valid=0, br_timeout=0, done=0, timeout counter=0.
- IDLE:
  - start=1 -> inst_addr_out<=start_addr, state<=RUN, fetch_valid<=1.
  - Otherwise hold; all other inputs ignored.
- RUN (priority halt > ctrl_branch > stall > advance):
  - halt -> HALTED, PC holds, fetch_valid<=0, done<=1.
  - ctrl_branch && br_resolved in the same cycle -> resolve immediately: PC<=br_target if take_branch, else PC+1. Stay in RUN.
  - ctrl_branch && !br_resolved -> BR_WAIT; PC holds; fetch_valid<=0; counter<=0.
  - stall -> PC holds, fetch_valid stays 1.
  - Else PC<=PC+1, modulo 2^A: 2^A-1 wraps to 0, no flag.
- BR_WAIT:
  - halt -> HALTED (overrides a same-cycle resolution).
  - br_resolved -> PC<=take_branch ? br_target : PC+1; RUN; fetch_valid<=1. stall is ignored on this resolving cycle.
  - Counter reaching BR_TIMEOUT-1 without resolution -> PC<=PC+1, RUN, fetch_valid<=1, br_timeout<=1 for exactly one cycle.
  - ctrl_branch and start are ignored.
- HALTED:
  - Absorbing; only reset exits.
  - PC frozen, done=1, fetch_valid=0; start/branch/stall ignored.
- take_branch and br_target are don't-care when br_resolved=0.
- Latency: every redirect appears on inst_addr_out one cycle after the sampling edge.

Optional Feature:
- Macro: FETCH_SEQUENCER_PERF_EN.
- Defined:
  - Adds outputs cycle_cnt[15:0] and fetch_cnt[15:0]; both reset to 0.
  - cycle_cnt increments every cycle in RUN or BR_WAIT.
  - fetch_cnt increments every RUN cycle with stall=0 and halt=0.
  - Both saturate at 16'hFFFF and freeze in HALTED.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan (A=4, BR_TIMEOUT=4):
- Start/sequential: reset 1 cycle, start=1, start_addr=3 -> PC 3,4,5,6…, fetch_valid=1 from the cycle after start; at PC=15 the next value is 0.
- Deferred taken branch: at PC=7 assert ctrl_branch; 2 cycles later br_resolved=1, take_branch=1, br_target=1 -> PC held at 7 with fetch_valid=0 while waiting, then PC=1, fetch_valid=1.
- Same-cycle resolution and not-taken: at PC=5, ctrl_branch=br_resolved=1, take_branch=0 -> PC=6 next cycle with no bubble; repeat with take_branch=1, br_target=12 -> PC=12.
- Timeout: at PC=9, ctrl_branch=1, never resolve -> after 4 BR_WAIT cycles PC=10, br_timeout high exactly 1 cycle.
- Stall/halt priority: stall=1 for 3 cycles at PC=2 -> PC stays 2; then halt=1 together with ctrl_branch=1 -> HALTED, done=1, PC frozen at 2, a later start ignored.
- Reset mid-branch: reset asserted during BR_WAIT -> next cycle IDLE, PC=0, fetch_valid=0, done=0; a fresh start works normally.
